muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_addsub.sv | 19 +
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states, default width and small op-decode helpers.
package muldiv_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic op_is_div(input logic [1:0] o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// (W+1)-bit adder/subtractor shared by the multiply and divide iterations.
// Combinational; cout is the carry out (no-borrow when subtracting).
module muldiv_addsub #(
  parameter int W = 32
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  input  logic       sub,
  output logic [W:0] sum,
  output logic       cout
);

  logic [W+1:0] full;

  assign full = {1'b0, a} + {1'b0, b ^ {(W+1){sub}}} + {{(W+1){1'b0}}, sub};
  assign sum  = full[W:0];
  assign cout = full[W+1];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULTU/MULT/DIVU/DIV unit: shift-add multiply, restoring divide,
// sign fix-up on magnitudes; done W+2 cycles after accept (2 for divide by zero).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div_zero
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e         state;
  op_e            op_q;
  logic           sign_a;
  logic           sign_b;
  logic           dz_pend;
  logic [W-1:0]   addend;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic           in_sa;
  logic           in_sb;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;

  logic [W:0]     as_a;
  logic [W:0]     as_b;
  logic [W:0]     as_sum;
  logic           as_sub;
  logic           as_cout;

  always_comb begin
    in_sa = op_is_signed(op) & A[W-1];
    in_sb = op_is_signed(op) & B[W-1];
    a_mag = in_sa ? -A : A;
    b_mag = in_sb ? -B : B;
  end

  // Multiply adds the multiplicand into the upper half; divide trial-subtracts
  // the divisor from the partial remainder shifted left by one quotient bit.
  always_comb begin
    as_sub = (state == S_DIV);
    as_a   = as_sub ? {acc[2*W-1:W], acc[W-1]} : {1'b0, acc[2*W-1:W]};
    as_b   = {1'b0, addend};
  end

  muldiv_addsub #(.W(W)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= OP_MULTU;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz_pend  <= 1'b0;
      addend   <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            sign_a  <= in_sa;
            sign_b  <= in_sb;
            busy    <= 1'b1;
            cnt     <= '0;
            dz_pend <= 1'b0;
            if (!op_is_div(op)) begin
              addend <= a_mag;
              acc    <= {{W{1'b0}}, b_mag};
              state  <= S_MUL;
            end else if (B == '0) begin
              // Zero divisor: preload the fixed result, no iterations.
              addend  <= '0;
              acc     <= {A, {W{1'b1}}};
              dz_pend <= 1'b1;
              state   <= S_FIX;
            end else begin
              addend <= b_mag;
              acc    <= {{W{1'b0}}, a_mag};
              state  <= S_DIV;
            end
          end
        end
        S_MUL: begin
          acc <= acc[0] ? {as_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= S_FIX;
        end
        S_DIV: begin
          acc <= {(as_cout ? as_sum[W-1:0] : as_a[W-1:0]), acc[W-2:0], as_cout};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (!dz_pend) begin
            case (op_q)
              OP_MULT: if (sign_a ^ sign_b) acc <= -acc;
              OP_DIV: begin
                acc[W-1:0]   <= (sign_a ^ sign_b) ? -acc[W-1:0] : acc[W-1:0];
                acc[2*W-1:W] <= sign_a ? -acc[2*W-1:W] : acc[2*W-1:W];
              end
              default: ;
            endcase
          end
          state <= S_DONE;
        end
        S_DONE: begin
          hi       <= acc[2*W-1:W];
          lo       <= acc[W-1:0];
          div_zero <= dz_pend;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
